// File: rtl/ysyx_wb_pkg.sv
// Shared constants and types for the NPC write-back controller.
// Optional operand bypass is enabled with YSYX_WB_BYPASS_EN.
package ysyx_wb_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  localparam int SRC_EXU = 0;
  localparam int SRC_LSU = 1;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_rec_t;

endpackage

// File: rtl/ysyx_rr_arb2.sv
// Two-request round-robin arbiter; rr_prio names the preferred
// requester when both are asserted and flips after each contention.
module ysyx_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_prio;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_prio <= 1'b0;
    end else if (&req) begin
      rr_prio <= ~rr_prio;
    end
  end

endmodule

// File: rtl/ysyx_wb_arbiter.sv
// Write-back port arbiter, registered output stage and busy scoreboard.
// Define YSYX_WB_BYPASS_EN to add the commit-cycle operand bypass.
module ysyx_wb_arbiter
  import ysyx_wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [AW-1:0]   exu_rd,
  input  logic [XLEN-1:0] exu_wdata,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic            iss_valid,
  input  logic            iss_rd_we,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  output logic            iss_stall,
`ifdef YSYX_WB_BYPASS_EN
  output logic            byp_hit1,
  output logic            byp_hit2,
  output logic [XLEN-1:0] byp_rdata1,
  output logic [XLEN-1:0] byp_rdata2,
`endif
  output logic            rf_wr_en,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  logic [1:0]      req;
  logic [1:0]      gnt;
  wb_rec_t         wb_d;
  wb_rec_t         wb_q;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_set;
  logic [NREG-1:0] busy_clr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_busy;
  logic            issue_fire;

  assign req[SRC_EXU] = exu_valid;
  assign req[SRC_LSU] = lsu_valid;

  ysyx_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign exu_ready = gnt[SRC_EXU];
  assign lsu_ready = gnt[SRC_LSU];

  // x0 writes still handshake but never reach the file
  always_comb begin
    wb_d = '0;
    if (gnt[SRC_LSU]) begin
      wb_d.rd   = lsu_rd;
      wb_d.data = lsu_wdata;
    end else if (gnt[SRC_EXU]) begin
      wb_d.rd   = exu_rd;
      wb_d.data = exu_wdata;
    end
    wb_d.valid = (|gnt) && (wb_d.rd != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign rf_wr_en = wb_q.valid;
  assign rf_waddr = wb_q.rd;
  assign rf_wdata = wb_q.data;

`ifdef YSYX_WB_BYPASS_EN
  assign byp_hit1   = rf_wr_en && (rf_waddr == iss_rs1)
                      && (iss_rs1 != '0);
  assign byp_hit2   = rf_wr_en && (rf_waddr == iss_rs2)
                      && (iss_rs2 != '0);
  assign byp_rdata1 = rf_wdata;
  assign byp_rdata2 = rf_wdata;
  assign rs1_busy   = busy[iss_rs1] && !byp_hit1;
  assign rs2_busy   = busy[iss_rs2] && !byp_hit2;
`else
  assign rs1_busy   = busy[iss_rs1];
  assign rs2_busy   = busy[iss_rs2];
`endif

  assign rd_busy    = iss_rd_we && busy[iss_rd];
  assign iss_stall  = iss_valid && (rs1_busy || rs2_busy || rd_busy);
  assign issue_fire = iss_valid && !iss_stall;

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue_fire && iss_rd_we && (iss_rd != '0)) begin
      busy_set[iss_rd] = 1'b1;
    end
    if (rf_wr_en) begin
      busy_clr[rf_waddr] = 1'b1;
    end
  end

  // set is applied after clear so a same-edge reissue stays busy;
  // bit 0 is masked so x0 never reads busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~busy_clr) | busy_set)
              & {{(NREG-1){1'b1}}, 1'b0};
    end
  end

endmodule

// File: tb/tb_ysyx_wb_arbiter.sv
// Scoreboard bench for ysyx_wb_arbiter; builds with or without
// YSYX_WB_BYPASS_EN.
module tb_ysyx_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, lsu_valid;
  logic        exu_ready, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd;
  logic [31:0] exu_wdata, lsu_wdata;
  logic        iss_valid, iss_rd_we;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_stall;
  logic        rf_wr_en;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef YSYX_WB_BYPASS_EN
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_rdata1, byp_rdata2;
`endif

  always #5 clk = ~clk;

  ysyx_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .exu_valid  (exu_valid),
    .exu_ready  (exu_ready),
    .exu_rd     (exu_rd),
    .exu_wdata  (exu_wdata),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_wdata  (lsu_wdata),
    .iss_valid  (iss_valid),
    .iss_rd_we  (iss_rd_we),
    .iss_rd     (iss_rd),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_stall  (iss_stall),
`ifdef YSYX_WB_BYPASS_EN
    .byp_hit1   (byp_hit1),
    .byp_hit2   (byp_hit2),
    .byp_rdata1 (byp_rdata1),
    .byp_rdata2 (byp_rdata2),
`endif
    .rf_wr_en   (rf_wr_en),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit [31:0] d;
  } exp_t;

  exp_t      sb_q[$];
  bit [31:0] m_busy;
  bit        m_prio;
  int        checks;
  int        failures;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    exu_valid = 0; exu_rd = 0; exu_wdata = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
    iss_valid = 0; iss_rd_we = 0;
    iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_busy = 0;
    m_prio = 0;
  endtask

  // one cycle: check outputs at negedge, update model, advance
  task automatic step();
    exp_t cur, nxt;
    bit   ge, gl, b1, b2, bd, stall;
    @(negedge clk);
    if (sb_q.size() > 0) cur = sb_q.pop_front();
    else cur = '{v: 0, rd: 0, d: 0};
    chk("rf_wr_en", rf_wr_en, cur.v);
    if (cur.v) begin
      chk("rf_waddr", rf_waddr, cur.rd);
      chk("rf_wdata", rf_wdata, cur.d);
    end
    ge = exu_valid && (!lsu_valid || !m_prio);
    gl = lsu_valid && (!exu_valid || m_prio);
    chk("exu_ready", exu_ready, ge);
    chk("lsu_ready", lsu_ready, gl);
    b1 = m_busy[iss_rs1];
    b2 = m_busy[iss_rs2];
`ifdef YSYX_WB_BYPASS_EN
    begin
      bit h1, h2;
      h1 = cur.v && cur.rd == iss_rs1 && iss_rs1 != 0;
      h2 = cur.v && cur.rd == iss_rs2 && iss_rs2 != 0;
      chk("byp_hit1", byp_hit1, h1);
      chk("byp_hit2", byp_hit2, h2);
      if (h1) chk("byp_rdata1", byp_rdata1, cur.d);
      if (h2) chk("byp_rdata2", byp_rdata2, cur.d);
      b1 = b1 && !h1;
      b2 = b2 && !h2;
    end
`endif
    bd = iss_rd_we && m_busy[iss_rd];
    stall = iss_valid && (b1 || b2 || bd);
    if (iss_valid) chk("iss_stall", iss_stall, stall);
    nxt = '{v: 0, rd: 0, d: 0};
    if (gl) begin
      nxt.rd = lsu_rd; nxt.d = lsu_wdata; nxt.v = lsu_rd != 0;
    end else if (ge) begin
      nxt.rd = exu_rd; nxt.d = exu_wdata; nxt.v = exu_rd != 0;
    end
    sb_q.push_back(nxt);
    if (cur.v) m_busy[cur.rd] = 0;
    if (iss_valid && !stall && iss_rd_we && iss_rd != 0)
      m_busy[iss_rd] = 1;
    if (exu_valid && lsu_valid) m_prio = ~m_prio;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    @(posedge clk); #1;
    rst = 0;

    // reset mid-write: pending commit and busy bits dropped at once
    exu_valid = 1; exu_rd = 6; exu_wdata = 32'h66;
    iss_valid = 1; iss_rd_we = 1; iss_rd = 6;
    step();
    idle_inputs();
    chk("pre_rst_wr_en", rf_wr_en, 1);
    rst = 1;
    iss_valid = 1; iss_rs1 = 6;
    #1;
    chk("midrst_wr_en", rf_wr_en, 0);
    chk("midrst_stall", iss_stall, 0);
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;

    // lone EXU write
    exu_valid = 1; exu_rd = 5; exu_wdata = 32'h1234;
    step();
    idle_inputs();
    step();

    // contention alternates EXU, LSU
    exu_valid = 1; exu_rd = 1;
    lsu_valid = 1; lsu_rd = 2;
    for (int i = 0; i < 4; i++) begin
      exu_wdata = 32'hA000 + i;
      lsu_wdata = 32'hB000 + i;
      step();
    end
    idle_inputs();
    step();

    // RAW on x3 clears only after commit (or bypasses at commit)
    iss_valid = 1; iss_rd_we = 1; iss_rd = 3;
    step();
    iss_rd_we = 0; iss_rd = 0; iss_rs1 = 3;
    exu_valid = 1; exu_rd = 3; exu_wdata = 32'h3333;
    step();
    exu_valid = 0;
    step();
    step();
    idle_inputs();

    // x0 write handshakes but never commits
    lsu_valid = 1; lsu_rd = 0; lsu_wdata = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    step();

    // same-edge set and clear of x7: set wins, then WAW stall
    exu_valid = 1; exu_rd = 7; exu_wdata = 32'h7777;
    step();
    idle_inputs();
    iss_valid = 1; iss_rd_we = 1; iss_rd = 7;
    step();
    step();
    idle_inputs();
    exu_valid = 1; exu_rd = 7; exu_wdata = 32'h7;
    step();
    idle_inputs();
    step();

    // commit-cycle read of x4
    iss_valid = 1; iss_rd_we = 1; iss_rd = 4;
    exu_valid = 1; exu_rd = 4; exu_wdata = 32'hCAFE;
    step();
    exu_valid = 0;
    iss_rd_we = 0; iss_rd = 0; iss_rs2 = 4;
    step();
    step();
    idle_inputs();
    step();

    // mixed random traffic
    for (int i = 0; i < 60; i++) begin
      exu_valid = $urandom_range(1);
      lsu_valid = $urandom_range(1);
      exu_rd = $urandom_range(7);
      lsu_rd = $urandom_range(7);
      exu_wdata = $urandom;
      lsu_wdata = $urandom;
      iss_valid = $urandom_range(1);
      iss_rd_we = $urandom_range(1);
      iss_rd = $urandom_range(7);
      iss_rs1 = $urandom_range(7);
      iss_rs2 = $urandom_range(7);
      step();
    end
    idle_inputs();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
